// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-back arbiter.
// Merges load results (priority, always accepted) and ALU results (valid/ready,
// buffered in a small FIFO) onto the single register-file write port, and reports
// which queried registers still have a write outstanding.
// Optional macro WB_FORWARD_EN adds fwd1_data/fwd2_data, which carry the data of
// the outstanding write to chk_rs1/chk_rs2.
module regfile_writeback_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] write_data,
  output logic            write_enable,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            rs1_pending,
  output logic            rs2_pending
`ifdef WB_FORWARD_EN
  ,
  output logic [XLEN-1:0] fwd1_data,
  output logic [XLEN-1:0] fwd2_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic full;
  logic empty;
  logic mem_sel;
  logic fifo_sel;
  logic byp_sel;
  logic alu_acc;
  logic push;
  logic pop;
  logic sel_any;
  logic [4:0]       sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Readiness comes from the pre-edge count, so a full FIFO never pushes even if it pops.
  assign alu_ready = !rst && !full;
  assign alu_acc   = alu_valid && alu_ready;

  // Load wins; buffered ALU results drain before a fresh ALU result may bypass.
  assign mem_sel  = mem_valid && (mem_rd != 5'd0);
  assign fifo_sel = !mem_sel && !empty;
  assign byp_sel  = !mem_sel && empty && alu_acc && (alu_rd != 5'd0);
  assign sel_any  = mem_sel || fifo_sel || byp_sel;

  // Accepted ALU results to x0 are dropped; the rest queue unless they bypass.
  assign push = alu_acc && (alu_rd != 5'd0) && !byp_sel;
  assign pop  = fifo_sel;

  // Mux the winning source onto the output-stage inputs.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    if (mem_sel) begin
      sel_rd   = mem_rd;
      sel_data = mem_data;
    end else if (fifo_sel) begin
      sel_rd   = fifo_rd[rd_ptr];
      sel_data = fifo_data[rd_ptr];
    end else if (byp_sel) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  // FIFO pointers and occupancy; everything buffered is discarded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful for slots covered by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= alu_rd;
      fifo_data[wr_ptr] <= alu_data;
    end
  end

  // Output stage: address/data hold when idle, only the strobe drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_enable <= 1'b0;
      a3           <= '0;
      write_data   <= '0;
    end else if (sel_any) begin
      write_enable <= 1'b1;
      a3           <= sel_rd;
      write_data   <= sel_data;
    end else begin
      write_enable <= 1'b0;
    end
  end

  // Per-slot liveness and destination match against both query registers.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] age;
      assign age             = PTR_W'(gi) - rd_ptr;
      assign entry_valid[gi] = ({1'b0, age} < count);
      assign hit1[gi]        = entry_valid[gi] && (fifo_rd[gi] == chk_rs1);
      assign hit2[gi]        = entry_valid[gi] && (fifo_rd[gi] == chk_rs2);
    end
  endgenerate

  assign rs1_pending = (chk_rs1 != 5'd0) && ((|hit1) || (write_enable && (a3 == chk_rs1)));
  assign rs2_pending = (chk_rs2 != 5'd0) && ((|hit2) || (write_enable && (a3 == chk_rs2)));

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Forward data: output stage lowest, then FIFO from oldest to youngest so the youngest wins.
  always_comb begin
    fwd1_data = '0;
    fwd2_data = '0;
    fwd_idx   = '0;
    if (write_enable && (a3 == chk_rs1)) fwd1_data = write_data;
    if (write_enable && (a3 == chk_rs2)) fwd2_data = write_data;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + PTR_W'(k);
      if ((PTR_W+1)'(k) < count) begin
        if (fifo_rd[fwd_idx] == chk_rs1) fwd1_data = fifo_data[fwd_idx];
        if (fifo_rd[fwd_idx] == chk_rs2) fwd2_data = fifo_data[fwd_idx];
      end
    end
    if (!rs1_pending) fwd1_data = '0;
    if (!rs2_pending) fwd2_data = '0;
  end
`else
  // Without forwarding, decode relies on the pending flags alone and stalls.
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed testbench for regfile_writeback_arbiter.
module tb_regfile_writeback_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            alu_valid = 1'b0;
  logic            alu_ready;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            mem_valid = 1'b0;
  logic [4:0]      mem_rd = '0;
  logic [XLEN-1:0] mem_data = '0;
  logic [4:0]      a3;
  logic [XLEN-1:0] write_data;
  logic            write_enable;
  logic [4:0]      chk_rs1 = '0;
  logic [4:0]      chk_rs2 = '0;
  logic            rs1_pending;
  logic            rs2_pending;
`ifdef WB_FORWARD_EN
  logic [XLEN-1:0] fwd1_data;
  logic [XLEN-1:0] fwd2_data;
`endif

  int total = 0;
  int bad = 0;

  regfile_writeback_arbiter #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .a3(a3), .write_data(write_data), .write_enable(write_enable),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending)
`ifdef WB_FORWARD_EN
    , .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%0h exp=0", write_enable); end
    total++; if (a3 !== 5'd0) begin bad++; $display("FAIL reset_a3 got=%0h exp=0", a3); end
    total++; if (write_data !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%0h exp=0", write_data); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0h exp=0", alu_ready); end
    chk_rs1 = 5'd1; chk_rs2 = 5'd2; #1;
    total++; if (rs1_pending !== 1'b0 || rs2_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%0h%0h exp=00", rs1_pending, rs2_pending); end
    chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    step(); step();
    rst = 1'b0; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0h exp=1", alu_ready); end
    $display("reset: we=%0h a3=%0h ready=%0h", write_enable, a3, alu_ready);
  endtask

  task automatic test_load();
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hDEADBEEF;
    step();
    mem_valid = 1'b0; chk_rs1 = 5'd5; #1;
    total++; if (write_enable !== 1'b1) begin bad++; $display("FAIL load_we got=%0h exp=1", write_enable); end
    total++; if (a3 !== 5'd5) begin bad++; $display("FAIL load_a3 got=%0h exp=5", a3); end
    total++; if (write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL load_wdata got=%0h exp=deadbeef", write_data); end
    total++; if (rs1_pending !== 1'b1) begin bad++; $display("FAIL load_pending_out got=%0h exp=1", rs1_pending); end
    step();
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL load_we_drop got=%0h exp=0", write_enable); end
    total++; if (a3 !== 5'd5 || write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL load_hold got=%0h/%0h exp=5/deadbeef", a3, write_data); end
    total++; if (rs1_pending !== 1'b0) begin bad++; $display("FAIL load_pending_clear got=%0h exp=0", rs1_pending); end
    chk_rs1 = 5'd0;
    $display("load: rd=5 data=deadbeef written");
  endtask

  task automatic test_bypass();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h11; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL byp_ready got=%0h exp=1", alu_ready); end
    step();
    alu_valid = 1'b0;
    total++; if (write_enable !== 1'b1 || a3 !== 5'd7 || write_data !== 32'h11) begin bad++; $display("FAIL byp_write got=%0h/%0h/%0h exp=1/7/11", write_enable, a3, write_data); end
    step();
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL byp_fifo_empty got=%0h exp=0", write_enable); end
    $display("bypass: rd=7 data=11 written directly");
  endtask

  task automatic test_mem_priority();
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h300;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h80; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL prio_ready0 got=%0h exp=1", alu_ready); end
    step();
    alu_rd = 5'd9; alu_data = 32'h90; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL prio_ready1 got=%0h exp=1", alu_ready); end
    total++; if (write_enable !== 1'b1 || a3 !== 5'd3) begin bad++; $display("FAIL prio_mem1 got=%0h/%0h exp=1/3", write_enable, a3); end
    step();
    alu_rd = 5'd10; alu_data = 32'hA0; chk_rs1 = 5'd8; chk_rs2 = 5'd9; #1;
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL prio_full got=%0h exp=0", alu_ready); end
    total++; if (rs1_pending !== 1'b1 || rs2_pending !== 1'b1) begin bad++; $display("FAIL prio_pending got=%0h%0h exp=11", rs1_pending, rs2_pending); end
`ifdef WB_FORWARD_EN
    total++; if (fwd1_data !== 32'h80 || fwd2_data !== 32'h90) begin bad++; $display("FAIL prio_fwd got=%0h/%0h exp=80/90", fwd1_data, fwd2_data); end
`endif
    chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    step();
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL prio_full2 got=%0h exp=0", alu_ready); end
    step();
    mem_valid = 1'b0; #1;
    total++; if (write_enable !== 1'b1 || a3 !== 5'd3 || write_data !== 32'h300) begin bad++; $display("FAIL prio_mem4 got=%0h/%0h/%0h exp=1/3/300", write_enable, a3, write_data); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL prio_full_pop got=%0h exp=0", alu_ready); end
    step();
    total++; if (write_enable !== 1'b1 || a3 !== 5'd8 || write_data !== 32'h80) begin bad++; $display("FAIL prio_w8 got=%0h/%0h/%0h exp=1/8/80", write_enable, a3, write_data); end
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL prio_ready_after got=%0h exp=1", alu_ready); end
    step();
    alu_valid = 1'b0;
    total++; if (write_enable !== 1'b1 || a3 !== 5'd9 || write_data !== 32'h90) begin bad++; $display("FAIL prio_w9 got=%0h/%0h/%0h exp=1/9/90", write_enable, a3, write_data); end
    step();
    total++; if (write_enable !== 1'b1 || a3 !== 5'd10 || write_data !== 32'hA0) begin bad++; $display("FAIL prio_w10 got=%0h/%0h/%0h exp=1/a/a0", write_enable, a3, write_data); end
    step();
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL prio_idle got=%0h exp=0", write_enable); end
    $display("mem_priority: writes 3,3,3,3,8,9,10 in order");
  endtask

  task automatic test_pending();
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h1;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
    step();
    mem_valid = 1'b0; alu_valid = 1'b0; chk_rs1 = 5'd12; chk_rs2 = 5'd0; #1;
    total++; if (rs1_pending !== 1'b1) begin bad++; $display("FAIL pend_fifo got=%0h exp=1", rs1_pending); end
    total++; if (rs2_pending !== 1'b0) begin bad++; $display("FAIL pend_x0 got=%0h exp=0", rs2_pending); end
    chk_rs2 = 5'd20; #1;
    total++; if (rs2_pending !== 1'b1) begin bad++; $display("FAIL pend_outstage got=%0h exp=1", rs2_pending); end
    chk_rs2 = 5'd0;
    step();
    total++; if (write_enable !== 1'b1 || a3 !== 5'd12 || rs1_pending !== 1'b1) begin bad++; $display("FAIL pend_retiring got=%0h/%0h/%0h exp=1/c/1", write_enable, a3, rs1_pending); end
    step();
    total++; if (rs1_pending !== 1'b0) begin bad++; $display("FAIL pend_retired got=%0h exp=0", rs1_pending); end
    chk_rs1 = 5'd0;
    $display("pending: rd=12 tracked through FIFO and output stage");
  endtask

  task automatic test_rd_zero();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h55;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h66; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL rd0_ready got=%0h exp=1", alu_ready); end
    step();
    mem_valid = 1'b0;
    alu_rd = 5'd13; alu_data = 32'hD0; #1;
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL rd0_nowrite got=%0h exp=0", write_enable); end
    step();
    alu_valid = 1'b0;
    // An x0 entry left in the FIFO would be popped here ahead of the bypass.
    total++; if (write_enable !== 1'b1 || a3 !== 5'd13 || write_data !== 32'hD0) begin bad++; $display("FAIL rd0_count got=%0h/%0h/%0h exp=1/d/d0", write_enable, a3, write_data); end
    step();
    $display("rd_zero: both x0 results consumed without write");
  endtask

  task automatic test_reset_mid();
    mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'h21;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4;
    step();
    alu_rd = 5'd6; alu_data = 32'h6;
    step();
    mem_valid = 1'b0; alu_valid = 1'b0; #1;
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%0h exp=0", alu_ready); end
    rst = 1'b1; chk_rs1 = 5'd4; chk_rs2 = 5'd6; #1;
    total++; if (write_enable !== 1'b0 || a3 !== 5'd0) begin bad++; $display("FAIL mid_async got=%0h/%0h exp=0/0", write_enable, a3); end
    total++; if (rs1_pending !== 1'b0 || rs2_pending !== 1'b0) begin bad++; $display("FAIL mid_pending got=%0h%0h exp=00", rs1_pending, rs2_pending); end
    step();
    rst = 1'b0; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0h exp=1", alu_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL mid_nowrite%0d got=%0h a3=%0h exp=0", i, write_enable, a3); end
    end
    chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    $display("reset_mid: buffered rd 4,6 discarded");
  endtask

  initial begin
    test_reset();
    test_load();
    test_bypass();
    test_mem_priority();
    test_pending();
    test_rd_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
